// File: rtl/fu_alu_simd_if.sv
// rtl/fu_alu_simd_if.sv - request/result bundle of the SIMD ALU functional unit
interface fu_alu_simd_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_op;
  logic                     in_sat;
  logic [LANES-1:0]         in_mask;
  logic [TAG_W-1:0]         in_tag;
  logic [LANES*WIDTH-1:0]   in_a;
  logic [LANES*WIDTH-1:0]   in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   out_result;
  logic [LANES-1:0]         out_neg;
  logic [LANES-1:0]         out_zero;
  logic [LANES-1:0]         out_ovf;
  logic [TAG_W-1:0]         out_tag;
  logic                     out_illegal;

  modport master (
    output flush, in_valid, in_op, in_sat, in_mask, in_tag, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_neg, out_zero, out_ovf, out_tag, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_op, in_sat, in_mask, in_tag, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_neg, out_zero, out_ovf, out_tag, out_illegal
  );
endinterface

// File: rtl/fu_alu_simd.sv
// rtl/fu_alu_simd.sv - multi-lane SIMD ALU with elastic STAGES-deep result pipeline
// Define FU_ALU_SAT_EN to let in_sat clamp overflowing ADD/SUB lanes.
module fu_alu_simd #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic          CLK,
  input logic          nRST,
  fu_alu_simd_if.slave bus
);
  localparam int VW   = LANES * WIDTH;
  localparam int SH_W = $clog2(WIDTH);
  localparam int M    = WIDTH - 1;
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns {signed_overflow, wrapped_result} for one lane.
  function automatic logic [WIDTH:0] lane_calc(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             ov;
    logic [SH_W-1:0]  sh;
    logic             lt_s;
    sh   = b[SH_W-1:0];
    lt_s = $signed(a) < $signed(b);
    r    = '0;
    ov   = 1'b0;
    case (op)
      4'd0:  begin r = a + b; ov = (a[M] == b[M]) && (r[M] != a[M]); end
      4'd1:  begin r = a - b; ov = (a[M] != b[M]) && (r[M] != a[M]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = a << sh;
      4'd7:  r = a >> sh;
      4'd8:  r = $signed(a) >>> sh;
      4'd9:  r = {{(WIDTH-1){1'b0}}, lt_s};
      4'd10: r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd11: r = lt_s ? a : b;
      4'd12: r = lt_s ? b : a;
      4'd13: r = a;
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  logic              c_ill;
  logic [VW-1:0]     c_res;
  logic [LANES-1:0]  c_neg, c_zero, c_ovf;

  assign c_ill = (bus.in_op >= 4'd14);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] val;
    logic             act;
    assign raw = lane_calc(bus.in_op, bus.in_a[l*WIDTH +: WIDTH], bus.in_b[l*WIDTH +: WIDTH]);
    assign act = bus.in_mask[l] && !c_ill;
`ifdef FU_ALU_SAT_EN
    // Overflow direction follows operand a's sign for both ADD and SUB.
    assign val = (bus.in_sat && raw[WIDTH]) ? (bus.in_a[l*WIDTH + M] ? S_MIN : S_MAX)
                                            : raw[WIDTH-1:0];
`else
    assign val = raw[WIDTH-1:0];
`endif
    assign c_res[l*WIDTH +: WIDTH] = act ? val : '0;
    assign c_neg[l]  = act && val[M];
    assign c_zero[l] = act && (val == '0);
    assign c_ovf[l]  = act && raw[WIDTH];
  end

`ifndef FU_ALU_SAT_EN
  logic unused_sat;
  assign unused_sat = bus.in_sat;
`endif

  logic [STAGES-1:0]                vld_q, vld_d;
  logic [STAGES-1:0][VW-1:0]        res_q, res_d;
  logic [STAGES-1:0][LANES-1:0]     neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [STAGES-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [STAGES-1:0]                ill_q, ill_d;
  logic [STAGES-1:0]                adv;
  logic                             accept;

  // A stage moves forward when downstream is empty or itself moving.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = vld_q[STAGES-1] && bus.out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = vld_q[i] && (!vld_q[i+1] || adv[i+1]);
    end
  end

  assign bus.in_ready = !bus.flush && (!vld_q[0] || adv[0]);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    vld_d  = vld_q;
    res_d  = res_q;
    neg_d  = neg_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    tag_d  = tag_q;
    ill_d  = ill_q;
    if (bus.flush) begin
      vld_d = '0;
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i-1]) begin
          vld_d[i]  = 1'b1;
          res_d[i]  = res_q[i-1];
          neg_d[i]  = neg_q[i-1];
          zero_d[i] = zero_q[i-1];
          ovf_d[i]  = ovf_q[i-1];
          tag_d[i]  = tag_q[i-1];
          ill_d[i]  = ill_q[i-1];
        end else if (adv[i]) begin
          vld_d[i] = 1'b0;
        end
      end
      if (accept) begin
        vld_d[0]  = 1'b1;
        res_d[0]  = c_res;
        neg_d[0]  = c_neg;
        zero_d[0] = c_zero;
        ovf_d[0]  = c_ovf;
        tag_d[0]  = bus.in_tag;
        ill_d[0]  = c_ill;
      end else if (adv[0]) begin
        vld_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q  <= '0;
      res_q  <= '0;
      neg_q  <= '0;
      zero_q <= '0;
      ovf_q  <= '0;
      tag_q  <= '0;
      ill_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      res_q  <= res_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      tag_q  <= tag_d;
      ill_q  <= ill_d;
    end
  end

  assign bus.out_valid   = vld_q[STAGES-1];
  assign bus.out_result  = res_q[STAGES-1];
  assign bus.out_neg     = neg_q[STAGES-1];
  assign bus.out_zero    = zero_q[STAGES-1];
  assign bus.out_ovf     = ovf_q[STAGES-1];
  assign bus.out_tag     = tag_q[STAGES-1];
  assign bus.out_illegal = ill_q[STAGES-1];
endmodule

// File: tb/tb_fu_alu_simd.sv
// tb/tb_fu_alu_simd.sv - scoreboard bench for fu_alu_simd against a lane-arithmetic model
module tb_fu_alu_simd;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int S  = 2;
  localparam int T  = 4;
  localparam int VW = W * L;
`ifdef FU_ALU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fu_alu_simd_if #(.WIDTH(W), .LANES(L), .TAG_W(T)) bus ();
  fu_alu_simd #(.WIDTH(W), .LANES(L), .STAGES(S), .TAG_W(T)) u_dut (
    .CLK(clk), .nRST(rst_n), .bus(bus));

  typedef struct {
    logic [VW-1:0] res;
    logic [L-1:0]  neg, zero, ovf;
    logic [T-1:0]  tag;
    logic          ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (bound expired)", nm);
  endtask

  // Each lane evaluated as signed/unsigned 64-bit integers, then truncated.
  function automatic exp_t model(input logic [3:0] op, input logic sat, input logic [L-1:0] mask,
                                 input logic [T-1:0] tag, input logic [VW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    longint sa, sb, ua, ub, r, mx, mn;
    int sh;
    bit ov;
    logic [W-1:0] rv;
    e.res = '0; e.neg = '0; e.zero = '0; e.ovf = '0; e.tag = tag; e.ill = (op >= 4'd14);
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -mx - 1;
    if (e.ill) return e;
    for (int l = 0; l < L; l++) begin
      if (!mask[l]) continue;
      sa = longint'($signed(a[l*W +: W]));
      sb = longint'($signed(b[l*W +: W]));
      ua = longint'(a[l*W +: W]);
      ub = longint'(b[l*W +: W]);
      sh = int'(ub % W);
      ov = 1'b0;
      case (op)
        4'd0, 4'd1: begin
          r  = (op == 4'd0) ? sa + sb : sa - sb;
          ov = (r > mx) || (r < mn);
          if (SAT_EN && sat && ov) r = (r > mx) ? mx : mn;
        end
        4'd2:  r = ua & ub;
        4'd3:  r = ua | ub;
        4'd4:  r = ua ^ ub;
        4'd5:  r = ~(ua | ub);
        4'd6:  r = ua << sh;
        4'd7:  r = ua >> sh;
        4'd8:  r = sa >>> sh;
        4'd9:  r = (sa < sb) ? 1 : 0;
        4'd10: r = (ua < ub) ? 1 : 0;
        4'd11: r = (sa < sb) ? sa : sb;
        4'd12: r = (sa > sb) ? sa : sb;
        default: r = ua;
      endcase
      rv = r[W-1:0];
      e.res[l*W +: W] = rv;
      e.neg[l]  = rv[W-1];
      e.zero[l] = (rv == '0);
      e.ovf[l]  = ov;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_lane();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b0, {(W-1){1'b1}}};
      4: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [VW-1:0] rep(input logic [W-1:0] x);
    return {L{x}};
  endfunction

  // Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [3:0] op, input logic sat, input logic [L-1:0] mask,
                      input logic [T-1:0] tag, input logic [VW-1:0] a, input logic [VW-1:0] b);
    int  n = 0;
    bit  done = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_sat = sat; bus.in_mask = mask;
    bus.in_tag = tag; bus.in_a = a; bus.in_b = b;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(op, sat, mask, tag, a, b));
        done = 1'b1;
      end else if (++n > 200) begin
        fail_now("accept_timeout");
        done = 1'b1;
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin : monitor
    exp_t e;
    logic [VW+3*L+T:0] cur, held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {bus.out_result, bus.out_neg, bus.out_zero, bus.out_ovf, bus.out_tag, bus.out_illegal};
      if (stalled && bus.out_valid) chk("hold_while_stalled", cur, held);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output tag=%0h", bus.out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.out_result, e.res);
          chk("flags_nzo", {bus.out_neg, bus.out_zero, bus.out_ovf}, {e.neg, e.zero, e.ovf});
          chk("tag_illegal", {bus.out_tag, bus.out_illegal}, {e.tag, e.ill});
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = cur;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    logic [VW-1:0] a, b;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0; bus.in_sat = 1'b0;
    bus.in_mask = '0; bus.in_tag = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_result", bus.out_result, '0);
    chk("rst_flags", {bus.out_neg, bus.out_zero, bus.out_ovf}, '0);
    chk("rst_tag_illegal", {bus.out_tag, bus.out_illegal}, '0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready, 1'b1);
    step();

    // Directed ADD with latency and constant-result check
    a = {32'h7FFF_FFFF, 32'd3, 32'd2, 32'd1};
    b = {32'd1, 32'd3, 32'd2, 32'd1};
    send(4'd0, 1'b0, 4'hF, 4'h5, a, b);
    for (int k = 0; k < S - 1; k++) begin
      @(negedge clk);
      chk("latency_not_early", bus.out_valid, 1'b0);
      step();
    end
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1'b1);
    chk("add_result", bus.out_result, {32'h8000_0000, 32'd6, 32'd4, 32'd2});
    chk("add_ovf_neg", {bus.out_ovf, bus.out_neg}, {4'b1000, 4'b1000});
    step();
    drain();

    // Backpressure: fill every slot, then release
    bus.out_ready = 1'b0;
    acc = 0;
    a = rep(32'd10); b = rep(32'd7);
    bus.in_op = 4'd0; bus.in_sat = 1'b0; bus.in_mask = 4'hF; bus.in_a = a; bus.in_b = b;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_tag = T'(acc + 1);
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(4'd0, 1'b0, 4'hF, T'(acc + 1), a, b));
        acc++;
      end
      step();
    end
    @(negedge clk);
    chk("bp_accepts", acc, S);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    step();
    bus.out_ready = 1'b1;
    send(4'd0, 1'b0, 4'hF, T'(acc + 1), a, b);
    drain();

    // Mask, illegal, shifts/compares, saturation
    send(4'd1, 1'b0, 4'b0101, 4'h1, rep(32'd5), rep(32'd5));
    send(4'd15, 1'b0, 4'hF, 4'hA, rep(32'h1234_5678), rep(32'h9));
    send(4'd8, 1'b0, 4'hF, 4'h2, rep(32'h8000_0000), rep(32'h21));
    send(4'd10, 1'b0, 4'hF, 4'h3, rep(32'd1), rep(32'hFFFF_FFFF));
    send(4'd11, 1'b0, 4'hF, 4'h4, rep(32'hFFFF_FFFF), rep(32'd1));
    send(4'd0, 1'b1, 4'hF, 4'h6, rep(32'h7FFF_FFFF), rep(32'd1));
    send(4'd1, 1'b1, 4'hF, 4'h7, rep(32'h8000_0000), rep(32'd1));
    send(4'd14, 1'b0, 4'h0, 4'hB, rep(32'd0), rep(32'd0));
    drain();

    // Flush with two ops in flight
    bus.out_ready = 1'b0;
    send(4'd2, 1'b0, 4'hF, 4'h8, rep(32'hF0F0_F0F0), rep(32'hFF00_FF00));
    send(4'd3, 1'b0, 4'hF, 4'h9, rep(32'hF0F0_F0F0), rep(32'hFF00_FF00));
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("flush_out_valid", bus.out_valid, 1'b0);
      step();
    end
    send(4'd4, 1'b0, 4'hF, 4'hC, rep(32'hAAAA_5555), rep(32'h0F0F_0F0F));
    drain();

    // Randomised traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        step();
      end else begin
        for (int l = 0; l < L; l++) begin
          a[l*W +: W] = rand_lane();
          b[l*W +: W] = rand_lane();
        end
        send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), L'($urandom),
             T'($urandom), a, b);
      end
    end
    drain();

    // Asynchronous reset with work in flight
    bus.out_ready = 1'b0;
    send(4'd13, 1'b0, 4'hF, 4'hD, rep(32'hDEAD_BEEF), rep(32'd0));
    send(4'd13, 1'b0, 4'hF, 4'hE, rep(32'hCAFE_F00D), rep(32'd0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 1'b0);
    chk("async_rst_outputs", {bus.out_result, bus.out_tag, bus.out_illegal}, '0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst2", bus.in_ready, 1'b1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fu_alu_simd.md
# fu_alu_simd

Parametrised multi-lane SIMD ALU functional unit for the tensor-core execute stage. Accepts one vector operation per cycle over a valid/ready handshake, computes it on `LANES` independent `WIDTH`-bit lanes, and returns the results with per-lane flags after a configurable pipeline depth. Supports backpressure, lane masking, tag passthrough for scoreboard matching, and a synchronous flush.

## Interface
Parameters:
- `WIDTH`, 32: lane width in bits (8..64, power of two).
- `LANES`, 4: lanes per operation (1..16).
- `STAGES`, 2: pipeline depth; latency in cycles (1..4).
- `TAG_W`, 4: width of the opaque request tag.

Ports:
- `CLK`  in  1  clock; all state changes on rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `flush`  in  1  drop all in-flight operations.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit accepts the request this cycle.
- `in_op`  in  4  operation code.
- `in_sat`  in  1  saturate ADD/SUB (see Configuration).
- `in_mask`  in  LANES  lane enable; 0 = lane inactive.
- `in_tag`  in  TAG_W  tag, returned unchanged.
- `in_a`, `in_b`  in  LANES*WIDTH  operands, lane i at bits [i*WIDTH +: WIDTH].
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  LANES*WIDTH  per-lane results.
- `out_neg`, `out_zero`, `out_ovf`  out  LANES each  per-lane flags.
- `out_tag`  out  TAG_W  tag of the result.
- `out_illegal`  out  1  op was reserved.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MIN (signed), 12 MAX (signed), 13 PASSA; 14–15 reserved.
- Shifts use `b[$clog2(WIDTH)-1:0]`; upper bits ignored. SLT/SLTU produce 1 or 0.
- ADD/SUB wrap modulo 2^WIDTH unless saturating. `out_ovf` = signed overflow for ADD/SUB, 0 for all other ops.
- `out_neg` = result MSB. `out_zero` = (result == 0).
- Masked lane (`in_mask[i]`=0): result 0, all three flags 0.
- Reserved op: all lane results and flags 0, `out_illegal`=1. Tag is still returned.
- Compute is combinational into stage 1. Stages 2..`STAGES` carry the registered result, flags, tag, and illegal bit.
- Each stage holds a valid bit. A stage advances when the next stage is empty or is advancing itself. The last stage advances on `out_ready`.
- `in_ready` = !flush && (stage 1 empty || stage 1 advancing).
- Acceptance requires `in_valid && in_ready`.
- Flush: all stage valid bits clear at the next edge. Requests presented during the flush cycle are not accepted. Flush has priority over acceptance and advance.
- Results leave in acceptance order; there is no reordering.

## Timing
- Reset (nRST low, async): all valid bits 0, `out_valid` 0. `out_result`, flags, `out_tag`, and `out_illegal` are 0. `in_ready` is 1 after reset release.
- Latency: a request accepted at edge N drives `out_valid` after edge N+`STAGES−1` when there is no backpressure. For STAGES=1, the result is visible in the cycle after acceptance.
- Throughput: 1 op/cycle with `out_ready` held high.
- Backpressure: with `out_ready` low, the unit accepts until all `STAGES` slots are full, then `in_ready` drops in the same cycle with no combinational loop beyond `out_ready`→`in_ready`. Bubbles collapse.
- Output stability: while `out_valid && !out_ready`, all `out_*` hold their values.
- Simultaneous accept and drain when full: both occur in the same cycle, and occupancy is unchanged.
- Reset mid-operation: in-flight ops are lost, and outputs return to their reset values immediately.

## Configuration
- `FU_ALU_SAT_EN` defined: ADD/SUB with `in_sat`=1 clamp an overflowing lane to 2^(WIDTH−1)−1 (positive overflow) or −2^(WIDTH−1) (negative overflow). `out_ovf` is still 1 for that lane.
- Undefined: `in_sat` is ignored, and ADD/SUB always wrap. The port remains present.

## Test plan
- WIDTH=32, LANES=4, STAGES=2, reset: ADD a={1,2,3,0x7FFFFFFF}, b={1,2,3,1}, mask=1111 → result {2,4,6,0x80000000}, ovf=1000, neg=1000, `out_valid` one edge after acceptance.
- Backpressure: hold `out_ready`=0 and stream 3 ops tagged 1,2,3 → `in_ready` drops after 2 accepts. Raise `out_ready` → tags come out 1,2,3 with no loss or duplication.
- Mask and illegal: SUB a=b=5 with mask=0101 → results 0 everywhere, zero flags=0101. Op 15 → `out_illegal`=1, all results 0, tag preserved.
- Shifts/compare: SRA a=0x80000000, b=0x21 (shamt 1) → 0xC0000000. SLTU a=1, b=0xFFFFFFFF → 1. MIN a=−1, b=1 → 0xFFFFFFFF.
- Flush: 2 ops in flight, assert flush with `in_valid`=1 → `in_ready`=0 that cycle and `out_valid`=0 on the following cycles. The next op completes normally.
- `FU_ALU_SAT_EN` with `in_sat`=1: ADD 0x7FFFFFFF+1 → 0x7FFFFFFF, ovf=1. SUB 0x80000000−1 → 0x80000000. Without the macro → wraps to 0x80000000 and 0x7FFFFFFF.
